// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin arbitration.
// Packets stay contiguous, and the output goes through a single registered beat buffer.
module stream_mux_rr #(
    parameter int  N  = 4,
    parameter int  W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready
);

    logic          lock;
    logic [SW-1:0] lock_ch;
    logic [SW-1:0] rr_ptr;

    logic          space;
    logic          gnt_vld;
    logic [SW-1:0] gnt;
    logic [N-1:0]  gnt_oh;
    logic [W-1:0]  gnt_data;
    logic          gnt_last;
    logic          accept;
    logic [SW-1:0] ptr_next;

    // Grant selection: a held lock ignores in_valid entirely so in_ready
    // cannot glitch on activity of the other channels mid-packet.
    always_comb begin
        space   = !out_valid || out_ready;
        gnt_vld = 1'b0;
        gnt     = '0;
        if (lock) begin
            gnt_vld = 1'b1;
            gnt     = lock_ch;
        end else if (!mode) begin
            if (32'(sel) < 32'(N)) begin
                gnt_vld = 1'b1;
                gnt     = sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!gnt_vld && in_valid[SW'((int'(rr_ptr) + k) % N)]) begin
                    gnt_vld = 1'b1;
                    gnt     = SW'((int'(rr_ptr) + k) % N);
                end
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            gnt_oh[i]   = gnt_vld && (gnt == SW'(i));
            in_ready[i] = gnt_oh[i] && space && rst_n;
            gnt_data    = gnt_data | (in_data[i*W +: W] & {W{gnt_oh[i]}});
        end
        gnt_last = |(gnt_oh & in_last);
        accept   = (|(gnt_oh & in_valid)) && space && rst_n;
        ptr_next = (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            lock      <= 1'b0;
            lock_ch   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_ch    <= gnt;
                out_last  <= gnt_last;
                if (gnt_last) begin
                    lock   <= 1'b0;
                    rr_ptr <= ptr_next;
                end else begin
                    lock    <= 1'b1;
                    lock_ch <= gnt;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a vector table for single-cycle behaviour plus
// hand-written sequences for reset, async reset mid-packet and out-of-range select.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    logic        mode5;
    logic [2:0]  sel5;
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_last5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_last5;
    logic        out_valid5;
    logic        out_ready5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.N(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_valid(in_valid5), .in_last(in_last5), .in_ready(in_ready5),
        .out_data(out_data5), .out_ch(out_ch5), .out_last(out_last5),
        .out_valid(out_valid5), .out_ready(out_ready5)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  och;
        logic        ol;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, check in_ready before the edge and the output register after it.
    task automatic step(input vec_t v, input string tag);
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.vld;
        in_last   = v.last;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(v.ov));
        check({tag, "_out_data"},  32'(out_data),  32'(v.od));
        check({tag, "_out_ch"},    32'(out_ch),    32'(v.och));
        check({tag, "_out_last"},  32'(out_last),  32'(v.ol));
    endtask

    initial begin
        // round-robin fairness, all channels valid with single-beat packets
        for (int r = 0; r < 6; r++)
            vecs.push_back(vec_t'{1'b1, 2'd0, 4'hF, 4'hF, 32'h33221100, 1'b1,
                                  4'(1 << (r % 4)), 1'b1, 8'(8'h11 * (r % 4)), 2'(r % 4), 1'b1});
        // fixed select, then drain with no new beat
        vecs.push_back(vec_t'{1'b0, 2'd2, 4'b0100, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd2, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd2, 1'b1});
        // ch1 three-beat packet; ch0/ch2 valid and mode/sel toggled mid-packet
        vecs.push_back(vec_t'{1'b1, 2'd0, 4'b0010, 4'b0000, 32'h00F211F0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 4'b0111, 4'b0000, 32'h00F212F0, 1'b1, 4'b0010, 1'b1, 8'h12, 2'd1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 2'd3, 4'b0111, 4'b0010, 32'h00F213F0, 1'b1, 4'b0010, 1'b1, 8'h13, 2'd1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd0, 4'b0101, 4'b0101, 32'h00F200F0, 1'b1, 4'b0100, 1'b1, 8'hF2, 2'd2, 1'b1});
        // backpressure: hold 0x3C for 3 cycles, then 0x3D with no bubble
        vecs.push_back(vec_t'{1'b0, 2'd0, 4'b0001, 4'b0001, 32'h0000003C, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0, 1'b1});
        for (int r = 0; r < 3; r++)
            vecs.push_back(vec_t'{1'b0, 2'd0, 4'b0001, 4'b0001, 32'h0000003D, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd0, 4'b0001, 4'b0001, 32'h0000003D, 1'b1, 4'b0001, 1'b1, 8'h3D, 2'd0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0001, 1'b0, 8'h3D, 2'd0, 1'b1});
        // round-robin with nothing valid: no grant
        vecs.push_back(vec_t'{1'b1, 2'd0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h3D, 2'd0, 1'b1});

        // reset held with every channel valid
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0;
        in_valid = 4'hF; in_last = 4'hF; in_data = 32'h33221100; out_ready = 1'b1;
        mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; in_last5 = 5'h1F;
        in_data5 = 40'hC4_33_22_11_00; out_ready5 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_ch",    32'(out_ch),    32'h0);
        check("rst_out_last",  32'(out_last),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("v%0d", i));

        // async reset between beats 1 and 2 of a ch3 packet
        step(vec_t'{1'b1, 2'd0, 4'b1000, 4'b0000, 32'h77000000, 1'b1, 4'b1000, 1'b1, 8'h77, 2'd3, 1'b0}, "ch3_beat1");
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_data",  32'(out_data),  32'h0);
        check("arst_out_last",  32'(out_last),  32'h0);
        check("arst_out_ch",    32'(out_ch),    32'h0);
        check("arst_in_ready",  32'(in_ready),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(vec_t'{1'b1, 2'd0, 4'b1001, 4'b1001, 32'h78000055, 1'b1, 4'b0001, 1'b1, 8'h55, 2'd0, 1'b1}, "post_arst");

        // N=5: out-of-range select gives no grant, sel=4 is valid
        check("n5_idle_out_valid", 32'(out_valid5), 32'h0);
        sel5 = 3'd6;
        #1;
        check("n5_sel6_in_ready", 32'(in_ready5), 32'h0);
        sel5 = 3'd5;
        #1;
        check("n5_sel5_in_ready", 32'(in_ready5), 32'h0);
        @(posedge clk);
        #1;
        check("n5_sel5_out_valid", 32'(out_valid5), 32'h0);
        sel5 = 3'd4;
        #1;
        check("n5_sel4_in_ready", 32'(in_ready5), 32'h10);
        @(posedge clk);
        #1;
        check("n5_sel4_out_valid", 32'(out_valid5), 32'h1);
        check("n5_sel4_out_ch",    32'(out_ch5),    32'h4);
        check("n5_sel4_out_data",  32'(out_data5),  32'hC4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
